// File: rtl/plru_pkg.sv
// plru_pkg: width derivations and tree pseudo-LRU update/victim functions shared by the tracker.
package plru_pkg;
  localparam int MAX_TREE_W = 15;
  localparam int MAX_WAY_W = 4;

  function automatic int plru_way_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int plru_set_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int plru_tree_w(input int ways);
    return ways - 1;
  endfunction

  // Trees are padded to the 16-way width; heap node n lives at bit ways-1-n.
  function automatic logic [MAX_TREE_W-1:0] plru_update(input logic [MAX_TREE_W-1:0] tree,
                                                        input logic [MAX_WAY_W-1:0] way,
                                                        input int ways);
    int node;
    int w;
    logic [3:0] idx;
    logic [1:0] wb;
    node = 1;
    w = plru_way_w(ways);
    plru_update = tree;
    for (int l = 0; l < MAX_WAY_W; l++)
      if (l < w) begin
        idx = 4'(ways - 1 - node);
        wb = 2'(w - 1 - l);
        plru_update[idx] = ~way[wb];
        node = 2 * node + int'(way[wb]);
      end
  endfunction

  function automatic logic [MAX_WAY_W-1:0] plru_victim(input logic [MAX_TREE_W-1:0] tree,
                                                       input int ways);
    int node;
    logic [3:0] idx;
    node = 1;
    for (int l = 0; l < MAX_WAY_W; l++)
      if (node < ways) begin
        idx = 4'(ways - 1 - node);
        node = 2 * node + int'(tree[idx]);
      end
    return 4'(node - ways);
  endfunction
endpackage

// File: rtl/plru_tree.sv
// plru_tree: one PLRU tree, optionally updated with an access, and the victim of the result.
module plru_tree
  import plru_pkg::*;
#(
  parameter int WAYS = 4,
  localparam int WAY_W = plru_way_w(WAYS),
  localparam int TREE_W = plru_tree_w(WAYS)
) (
  input  logic [TREE_W-1:0] tree,
  input  logic [WAY_W-1:0]  way,
  input  logic              upd,
  output logic [TREE_W-1:0] next,
  output logic [WAY_W-1:0]  victim
);
  assign next = upd ? TREE_W'(plru_update(MAX_TREE_W'(tree), MAX_WAY_W'(way), WAYS)) : tree;
  assign victim = WAY_W'(plru_victim(MAX_TREE_W'(next), WAYS));
endmodule

// File: rtl/plru_tracker.sv
// plru_tracker: per-set tree PLRU state with write-first victim queries and invalid-way priority.
module plru_tracker
  import plru_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 32,
  localparam int WAY_W = plru_way_w(WAYS),
  localparam int SET_W = plru_set_w(SETS),
  localparam int TREE_W = plru_tree_w(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              acc_valid,
  input  logic [SET_W-1:0]  acc_set,
  input  logic [WAY_W-1:0]  acc_way,
  input  logic              vict_req,
  input  logic [SET_W-1:0]  vict_set,
  input  logic [WAYS-1:0]   vict_vmask,
  output logic              vict_valid,
  output logic [WAY_W-1:0]  vict_way,
  output logic [TREE_W-1:0] tree_dbg
);
  logic [TREE_W-1:0] state [SETS];
  logic [TREE_W-1:0] acc_next;
  logic [TREE_W-1:0] vict_tree;
  logic [TREE_W-1:0] unused_next;
  logic [WAY_W-1:0]  tree_way;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  unused_victim;
  logic              bypass;

  assign tree_dbg = state[acc_set];
  // The query path sees the zeroed tree under flush, or this cycle's access to the same set.
  assign vict_tree = flush ? '0 : state[vict_set];
  assign bypass = acc_valid && !flush && acc_set == vict_set;

  plru_tree #(.WAYS(WAYS)) u_acc (
    .tree(state[acc_set]), .way(acc_way), .upd(1'b1), .next(acc_next), .victim(unused_victim)
  );

  plru_tree #(.WAYS(WAYS)) u_vict (
    .tree(vict_tree), .way(acc_way), .upd(bypass), .next(unused_next), .victim(tree_way)
  );

  always_comb begin
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) inv_way = vict_vmask[i] ? inv_way : WAY_W'(i);
  end

  always_ff @(posedge clk) begin
    if (rst || flush)
      for (int i = 0; i < SETS; i++) state[i] <= '0;
    else if (acc_valid)
      state[acc_set] <= acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vict_valid <= 1'b0;
      vict_way <= '0;
    end else begin
      vict_valid <= vict_req;
      if (vict_req) vict_way <= &vict_vmask ? tree_way : inv_way;
    end
  end
endmodule

// File: tb/tb_plru_tracker.sv
// tb_plru_tracker: table, directed and random checks of 4-way and 8-way trackers against a heap-array model.
module tb_plru_tracker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic fl4, av4, vr4, vv4;
  logic [4:0] aset4, vset4;
  logic [1:0] away4, vw4;
  logic [3:0] vmask4;
  logic [2:0] dbg4;

  logic fl8, av8, vr8, vv8;
  logic [1:0] aset8, vset8;
  logic [2:0] away8, vw8;
  logic [7:0] vmask8;
  logic [6:0] dbg8;

  plru_tracker #(.WAYS(4), .SETS(32)) u4 (
    .clk(clk), .rst(rst), .flush(fl4), .acc_valid(av4), .acc_set(aset4), .acc_way(away4),
    .vict_req(vr4), .vict_set(vset4), .vict_vmask(vmask4), .vict_valid(vv4), .vict_way(vw4),
    .tree_dbg(dbg4)
  );

  plru_tracker #(.WAYS(8), .SETS(4)) u8 (
    .clk(clk), .rst(rst), .flush(fl8), .acc_valid(av8), .acc_set(aset8), .acc_way(away8),
    .vict_req(vr8), .vict_set(vset8), .vict_vmask(vmask8), .vict_valid(vv8), .vict_way(vw8),
    .tree_dbg(dbg8)
  );

  int n_chk = 0;
  int n_fail = 0;

  // mdl[dut][set][node]: heap-indexed node bits, 1 = least recently used side is the upper subtree
  bit mdl [2][32][16];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mclear(input int d);
    for (int s = 0; s < 32; s++)
      for (int n = 0; n < 16; n++) mdl[d][s][n] = 1'b0;
  endtask

  // Climb from the leaf: each ancestor points away from the child we came from.
  task automatic mupd(input int d, input int s, input int w, input int ways);
    for (int n = ways + w; n > 1; n = n / 2) mdl[d][s][n/2] = (n % 2 == 0);
  endtask

  function automatic int mvict(input int d, input int s, input int ways);
    int n = 1;
    while (n < ways) n = 2 * n + int'(mdl[d][s][n]);
    return n - ways;
  endfunction

  function automatic int mdbg(input int d, input int s, input int ways);
    int r = 0;
    for (int n = 1; n < ways; n++) if (mdl[d][s][n]) r |= 1 << (ways - 1 - n);
    return r;
  endfunction

  task automatic idle;
    {fl4, av4, vr4, fl8, av8, vr8} = '0;
    {aset4, vset4, away4, aset8, vset8, away8} = '0;
    vmask4 = '1;
    vmask8 = '1;
  endtask

  task automatic step(input int d, input bit fl, input bit av, input int aset, input int away,
                      input bit vr, input int vset, input int vmask);
    int ways = d ? 8 : 4;
    int ew = -1;
    if (d == 0) begin
      fl4 = fl; av4 = av; aset4 = 5'(aset); away4 = 2'(away);
      vr4 = vr; vset4 = 5'(vset); vmask4 = 4'(vmask);
    end else begin
      fl8 = fl; av8 = av; aset8 = 2'(aset); away8 = 3'(away);
      vr8 = vr; vset8 = 2'(vset); vmask8 = 8'(vmask);
    end
    if (fl) mclear(d);
    else if (av) mupd(d, aset, away, ways);
    for (int i = 0; i < ways; i++) if (ew < 0 && !vmask[i]) ew = i;
    if (ew < 0) ew = mvict(d, vset, ways);
    @(posedge clk);
    @(negedge clk);
    check(d ? "vict_valid8" : "vict_valid4", d ? int'(vv8) : int'(vv4), int'(vr));
    if (vr) check(d ? "vict_way8" : "vict_way4", d ? int'(vw8) : int'(vw4), ew);
    check(d ? "tree_dbg8" : "tree_dbg4", d ? int'(dbg8) : int'(dbg4), mdbg(d, aset, ways));
  endtask

  task automatic reset_with_query;
    rst = 1'b1;
    vr4 = 1'b1;
    vr8 = 1'b1;
    vmask4 = 4'b0111;
    vmask8 = 8'h7f;
    @(posedge clk);
    @(negedge clk);
    check("rst_no_resp4", int'(vv4), 0);
    check("rst_no_resp8", int'(vv8), 0);
    check("rst_way4", int'(vw4), 0);
    rst = 1'b0;
    idle();
    mclear(0);
    mclear(1);
  endtask

  typedef struct {
    bit fl;
    bit av;
    int aset;
    int away;
    bit vr;
    int vset;
    int vmask;
    int ew;
    int edbg;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 0, 5, 0, 1, 5, 15, 0, 0};
    tbl[1]  = '{0, 1, 3, 0, 0, 0, 15, 0, 6};
    tbl[2]  = '{0, 1, 3, 2, 0, 0, 15, 0, 3};
    tbl[3]  = '{0, 1, 3, 1, 0, 0, 15, 0, 5};
    tbl[4]  = '{0, 0, 3, 0, 1, 3, 15, 3, 5};
    tbl[5]  = '{0, 1, 2, 0, 1, 2, 15, 2, 6};
    tbl[6]  = '{0, 1, 7, 0, 0, 0, 15, 0, 6};
    tbl[7]  = '{0, 1, 7, 2, 0, 0, 15, 0, 3};
    tbl[8]  = '{0, 0, 7, 0, 1, 7, 11, 2, 3};
    tbl[9]  = '{0, 0, 7, 0, 1, 7, 15, 1, 3};
    tbl[10] = '{1, 1, 3, 3, 1, 3, 15, 0, 0};
    tbl[11] = '{0, 0, 2, 0, 1, 2, 15, 0, 0};
    tbl[12] = '{0, 0, 7, 0, 1, 7, 15, 0, 0};
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_with_query();
    for (int i = 0; i < 13; i++) begin
      step(0, tbl[i].fl, tbl[i].av, tbl[i].aset, tbl[i].away, tbl[i].vr, tbl[i].vset, tbl[i].vmask);
      if (tbl[i].vr) check($sformatf("tbl%0d_way", i), int'(vw4), tbl[i].ew);
      check($sformatf("tbl%0d_dbg", i), int'(dbg4), tbl[i].edbg);
      idle();
    end
    for (int w = 0; w < 7; w++) step(1, 0, 1, 0, w, 0, 0, 255);
    step(1, 0, 0, 0, 0, 1, 0, 255);
    step(1, 0, 1, 0, 7, 0, 0, 255);
    step(1, 0, 0, 0, 0, 1, 0, 255);
    for (int s = 1; s < 4; s++) step(1, 0, 1, s, s + 3, 0, 0, 255);
    step(1, 1, 1, 1, 5, 1, 2, 255);
    for (int s = 0; s < 4; s++) step(1, 0, 0, s, 0, 1, s, 255);
    idle();
    for (int k = 0; k < 600; k++) begin
      int d = int'($urandom_range(0, 1));
      int ways = d ? 8 : 4;
      int sets = d ? 4 : 32;
      int vm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << ways) - 1)) : (1 << ways) - 1;
      bit same = ($urandom_range(0, 3) == 0);
      int as = int'($urandom_range(0, sets - 1));
      step(d, $urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, as,
           int'($urandom_range(0, ways - 1)), $urandom_range(0, 2) != 0,
           same ? as : int'($urandom_range(0, sets - 1)), vm);
      idle();
    end
    step(0, 0, 1, 9, 1, 0, 0, 15);
    idle();
    reset_with_query();
    step(0, 0, 0, 9, 0, 1, 9, 15);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
